// File: rtl/sic_exec_alu_mc_if.sv
// ---------------------------------------------------------------------------
// sic_exec_alu_mc_if
// Bundles every non-clock/reset signal of sic_exec_alu_mc.
//   slave  : the execution unit side (sic_exec_alu_mc)
//   master : the surrounding pipeline / ALU / ECR file side
// Groups: packet handshake (pkt_*), operand readiness (rs_*/rt_*), ALU lock
// and request/answer (alu_*), ECR read/write (ecr_*), GPR writeback (wb_*),
// status and statistics (busy, retired_cnt, aborted_cnt).
// ---------------------------------------------------------------------------
interface sic_exec_alu_mc_if #(
    parameter int DATA_W  = 32,
    parameter int ID_W    = 4,
    parameter int NUM_ECR = 4,
    parameter int CNT_W   = 16
);
    localparam int ECR_AW = $clog2(NUM_ECR);

    logic              pkt_valid;
    logic              pkt_ready;
    logic [ID_W-1:0]   pkt_issue_id;
    logic [ECR_AW-1:0] pkt_dep_ecr;
    logic [ECR_AW-1:0] pkt_set_ecr;
    logic              pkt_pred_taken;
    logic              pkt_write_gpr;
    logic              pkt_write_ecr;
    logic              pkt_b_is_imm;
    logic [DATA_W-1:0] pkt_imm;
    logic [3:0]        pkt_alu_op;
    logic [1:0]        pkt_cond;

    logic              rs_valid;
    logic              rt_valid;
    logic [DATA_W-1:0] rs_data;
    logic [DATA_W-1:0] rt_data;

    logic              alu_lock_req;
    logic [ID_W-1:0]   alu_lock_id;
    logic              alu_grant;
    logic              alu_release;
    logic              alu_req_valid;
    logic [3:0]        alu_op;
    logic [DATA_W-1:0] alu_a;
    logic [DATA_W-1:0] alu_b;
    logic              alu_ans_valid;
    logic [DATA_W-1:0] alu_c;
    logic              alu_zero;
    logic              alu_neg;

    logic              ecr_rd_en;
    logic [ECR_AW-1:0] ecr_rd_addr;
    logic [1:0]        ecr_rd_data;
    logic              ecr_wen;
    logic [ECR_AW-1:0] ecr_waddr;
    logic [1:0]        ecr_wdata;

    logic              wb_commit;
    logic [DATA_W-1:0] wb_data;
    logic              busy;
    logic [CNT_W-1:0]  retired_cnt;
    logic [CNT_W-1:0]  aborted_cnt;

    modport slave (
        input  pkt_valid, pkt_issue_id, pkt_dep_ecr, pkt_set_ecr, pkt_pred_taken,
               pkt_write_gpr, pkt_write_ecr, pkt_b_is_imm, pkt_imm, pkt_alu_op, pkt_cond,
               rs_valid, rt_valid, rs_data, rt_data,
               alu_grant, alu_ans_valid, alu_c, alu_zero, alu_neg, ecr_rd_data,
        output pkt_ready, alu_lock_req, alu_lock_id, alu_release, alu_req_valid,
               alu_op, alu_a, alu_b, ecr_rd_en, ecr_rd_addr, ecr_wen, ecr_waddr,
               ecr_wdata, wb_commit, wb_data, busy, retired_cnt, aborted_cnt
    );

    modport master (
        output pkt_valid, pkt_issue_id, pkt_dep_ecr, pkt_set_ecr, pkt_pred_taken,
               pkt_write_gpr, pkt_write_ecr, pkt_b_is_imm, pkt_imm, pkt_alu_op, pkt_cond,
               rs_valid, rt_valid, rs_data, rt_data,
               alu_grant, alu_ans_valid, alu_c, alu_zero, alu_neg, ecr_rd_data,
        input  pkt_ready, alu_lock_req, alu_lock_id, alu_release, alu_req_valid,
               alu_op, alu_a, alu_b, ecr_rd_en, ecr_rd_addr, ecr_wen, ecr_waddr,
               ecr_wdata, wb_commit, wb_data, busy, retired_cnt, aborted_cnt
    );
endinterface

// File: rtl/sic_exec_alu_mc.sv
// ---------------------------------------------------------------------------
// sic_exec_alu_mc
// Multi-cycle ALU execution unit: accepts one packet, locks the shared ALU,
// waits for operands, launches the ALU, waits for its variable-latency answer,
// waits for the dependency ECR to resolve, then commits the GPR result and/or
// a branch-resolution ECR value and releases the lock. An ECR value of 2'b10
// seen on the dependency read aborts the packet from any active state.
// Ports:
//   clk   : clock
//   rst_n : asynchronous active-low reset
//   bus   : sic_exec_alu_mc_if.slave (packet, operands, ALU, ECR, writeback,
//           status/statistics)
// ---------------------------------------------------------------------------
module sic_exec_alu_mc #(
    parameter int DATA_W  = 32,
    parameter int ID_W    = 4,
    parameter int NUM_ECR = 4,
    parameter int CNT_W   = 16
) (
    input  logic                clk,
    input  logic                rst_n,
    sic_exec_alu_mc_if.slave    bus
);
    localparam int ECR_AW = $clog2(NUM_ECR);

    typedef enum logic [2:0] {
        IDLE, REQ_LOCKS, ISSUE, WAIT_ALU, CHECK_ECR, COMMIT, RELEASE
    } state_t;

    state_t            state_q, state_d;
    logic [ID_W-1:0]   id_q;
    logic [ECR_AW-1:0] dep_q, set_q;
    logic              pred_q, wgpr_q, wecr_q, bimm_q;
    logic [DATA_W-1:0] imm_q;
    logic [3:0]        op_q;
    logic [1:0]        cond_q;
    logic [DATA_W-1:0] a_q, b_q, c_q;
    logic              zero_q, neg_q;
    logic              granted_q;
    logic [CNT_W-1:0]  ret_q, abt_q;

    logic abort, operands_ok, commit_fire, taken;

    always_comb begin
        // ecr_rd_en is high in every non-IDLE state, so abort needs only the state check
        abort       = (state_q != IDLE) && (state_q != RELEASE) && (bus.ecr_rd_data == 2'b10);
        operands_ok = bus.alu_grant && bus.rs_valid && (bimm_q || bus.rt_valid);
        commit_fire = (state_q == COMMIT) && !abort;
        case (cond_q)
            2'd0:    taken = zero_q;
            2'd1:    taken = !zero_q;
            2'd2:    taken = neg_q;
            default: taken = !neg_q;
        endcase

        state_d = state_q;
        case (state_q)
            IDLE:      if (bus.pkt_valid) state_d = REQ_LOCKS;
            REQ_LOCKS: if (operands_ok) state_d = ISSUE;
            ISSUE:     state_d = WAIT_ALU;
            WAIT_ALU:  if (bus.alu_ans_valid) state_d = CHECK_ECR;
            CHECK_ECR: if (bus.ecr_rd_data == 2'b01) state_d = COMMIT;
            COMMIT:    state_d = RELEASE;
            RELEASE:   state_d = IDLE;
            default:   state_d = IDLE;
        endcase
        if (abort) state_d = RELEASE;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            id_q      <= '0;
            dep_q     <= '0;
            set_q     <= '0;
            pred_q    <= 1'b0;
            wgpr_q    <= 1'b0;
            wecr_q    <= 1'b0;
            bimm_q    <= 1'b0;
            imm_q     <= '0;
            op_q      <= '0;
            cond_q    <= '0;
            a_q       <= '0;
            b_q       <= '0;
            c_q       <= '0;
            zero_q    <= 1'b0;
            neg_q     <= 1'b0;
            granted_q <= 1'b0;
            ret_q     <= '0;
            abt_q     <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == IDLE && bus.pkt_valid) begin
                id_q   <= bus.pkt_issue_id;
                dep_q  <= bus.pkt_dep_ecr;
                set_q  <= bus.pkt_set_ecr;
                pred_q <= bus.pkt_pred_taken;
                wgpr_q <= bus.pkt_write_gpr;
                wecr_q <= bus.pkt_write_ecr;
                bimm_q <= bus.pkt_b_is_imm;
                imm_q  <= bus.pkt_imm;
                op_q   <= bus.pkt_alu_op;
                cond_q <= bus.pkt_cond;
            end
            // Lock ownership is recorded only on a real REQ_LOCKS exit, so an
            // abort before grant reaches RELEASE without a release pulse.
            if (state_q == REQ_LOCKS && state_d == ISSUE) granted_q <= 1'b1;
            if (state_q == RELEASE) granted_q <= 1'b0;
            if (state_q == ISSUE) begin
                a_q <= bus.rs_data;
                b_q <= bimm_q ? imm_q : bus.rt_data;
            end
            if (state_q == WAIT_ALU && bus.alu_ans_valid) begin
                c_q    <= bus.alu_c;
                zero_q <= bus.alu_zero;
                neg_q  <= bus.alu_neg;
            end
            if (commit_fire) ret_q <= ret_q + 1'b1;
            if (abort)       abt_q <= abt_q + 1'b1;
        end
    end

    // Operands are presented live in the launch cycle and held from registers after it.
    assign bus.alu_a         = (state_q == ISSUE) ? bus.rs_data : a_q;
    assign bus.alu_b         = (state_q == ISSUE) ? (bimm_q ? imm_q : bus.rt_data) : b_q;
    assign bus.alu_op        = op_q;
    assign bus.alu_req_valid = (state_q == ISSUE);
    assign bus.alu_lock_req  = (state_q == REQ_LOCKS) || (state_q == ISSUE) ||
                               (state_q == WAIT_ALU) || (state_q == CHECK_ECR) ||
                               (state_q == COMMIT);
    assign bus.alu_lock_id   = id_q;
    assign bus.alu_release   = (state_q == RELEASE) && granted_q;
    assign bus.pkt_ready     = (state_q == IDLE);
    assign bus.busy          = (state_q != IDLE);
    assign bus.ecr_rd_en     = (state_q != IDLE);
    assign bus.ecr_rd_addr   = dep_q;
    assign bus.ecr_wen       = commit_fire && wecr_q;
    assign bus.ecr_waddr     = set_q;
    assign bus.ecr_wdata     = (commit_fire && wecr_q) ? ((taken == pred_q) ? 2'b01 : 2'b10) : 2'b00;
    assign bus.wb_commit     = commit_fire && wgpr_q;
    assign bus.wb_data       = c_q;
    assign bus.retired_cnt   = ret_q;
    assign bus.aborted_cnt   = abt_q;
endmodule

// File: doc/sic_exec_alu_mc.md
SIC_EXEC_ALU_MC -- requirements
Module: sic_exec_alu_mc

Interface
REQ-001 SHALL have parameter DATA_W, default 32: operand/result width.
REQ-002 SHALL have parameter ID_W, default 4: issue-id width.
REQ-003 SHALL have parameter NUM_ECR, default 4 (>=2): ECR entries; ECR_AW = clog2(NUM_ECR).
REQ-004 SHALL have parameter CNT_W, default 16: statistics counter width.
REQ-005 SHALL have ports:
 clk  in  1  clock
 rst_n  in  1  reset, asynchronous, active-low
 pkt_valid  in  1  packet offered
 pkt_ready  out  1  unit accepts packet
 pkt_issue_id  in  ID_W  issue id
 pkt_dep_ecr / pkt_set_ecr  in  ECR_AW  ECR read / ECR write index
 pkt_pred_taken  in  1  predicted branch outcome
 pkt_write_gpr / pkt_write_ecr  in  1  commit GPR result / commit ECR
 pkt_b_is_imm  in  1  operand B = pkt_imm
 pkt_imm  in  DATA_W  pre-extended immediate
 pkt_alu_op  in  4  ALU opcode, passed through
 pkt_cond  in  2  0=zero,1=nonzero,2=negative,3=non-negative
 rs_valid, rt_valid  in  1  operand ready
 rs_data, rt_data  in  DATA_W  operand values
 alu_lock_req  out  1  ALU lock request
 alu_lock_id  out  ID_W  latched issue id
 alu_grant  in  1  lock granted
 alu_release  out  1  one-cycle lock release
 alu_req_valid  out  1  one-cycle ALU launch
 alu_op  out  4; alu_a, alu_b  out  DATA_W  ALU request
 alu_ans_valid  in  1  result ready (variable latency)
 alu_c  in  DATA_W; alu_zero, alu_neg  in  1  ALU result
 ecr_rd_en  out  1; ecr_rd_addr  out  ECR_AW; ecr_rd_data  in  2  ECR read
 ecr_wen  out  1; ecr_waddr  out  ECR_AW; ecr_wdata  out  2  ECR write
 wb_commit  out  1; wb_data  out  DATA_W  GPR commit
 busy  out  1  state != IDLE
 retired_cnt, aborted_cnt  out  CNT_W  statistics

Function
REQ-006 SHALL implement states IDLE, REQ_LOCKS, ISSUE, WAIT_ALU, CHECK_ECR, COMMIT, RELEASE.
REQ-007 IDLE: pkt_ready=1; on pkt_valid latch all pkt_* fields, go REQ_LOCKS; pkt_ready=0 in all other states.
REQ-008 REQ_LOCKS: alu_lock_req=1; advance to ISSUE when alu_grant && (pkt_b_is_imm || rt_valid) && rs_valid in the same cycle; otherwise hold.
REQ-009 alu_lock_req SHALL stay 1 in REQ_LOCKS through COMMIT; alu_lock_id = latched issue id.
REQ-010 ISSUE: alu_req_valid=1 for exactly one cycle, alu_a=rs_data, alu_b=pkt_b_is_imm ? imm : rt_data, both sampled that cycle and held registered until next ISSUE; go WAIT_ALU.
REQ-011 WAIT_ALU: on alu_ans_valid latch alu_c, alu_zero, alu_neg, go CHECK_ECR; alu_ans_valid in the ISSUE cycle itself SHALL be ignored.
REQ-012 ecr_rd_en=1 in every state except IDLE; ecr_rd_addr = latched dep index.
REQ-013 CHECK_ECR: ecr_rd_data 01 -> COMMIT; 00 or 11 -> hold.
REQ-014 Abort: ecr_rd_en && ecr_rd_data==10 in any state except RELEASE -> next state RELEASE, aborted_cnt+1, no commit; abort has priority over all other transitions.
REQ-015 COMMIT (combinational, suppressed by same-cycle abort): wb_commit=pkt_write_gpr, wb_data=latched result; ecr_wen=pkt_write_ecr, ecr_waddr=latched set index, ecr_wdata = (taken==pred) ? 01 : 10, taken from pkt_cond on latched zero/neg; retired_cnt+1; go RELEASE.
REQ-016 RELEASE: alu_release=1 for one cycle only if lock was granted (state passed REQ_LOCKS exit); go IDLE; next packet acceptable the following cycle.
REQ-017 Counters SHALL wrap modulo 2^CNT_W without saturation.

Reset
REQ-018 rst_n low SHALL asynchronously force IDLE, both counters 0, all outputs 0 except pkt_ready=1; reset mid-operation drops the packet with no release pulse.

Verification
REQ-019 Scenarios:
 - add rs=5, rt=7, ALU answers 3 cycles after launch, dep ECR=01, write_gpr -> one wb_commit with wb_data=12, alu_release one cycle later, retired_cnt=1.
 - branch cond=0, pred_taken=1, alu_zero=1, set_ecr=3 (NUM_ECR=4) -> ecr_wen pulse, waddr=3, wdata=01; repeat with alu_zero=0 -> wdata=10.
 - dep ECR=00 for 10 cycles then 10 while in CHECK_ECR -> no wb_commit/ecr_wen, alu_release pulse, aborted_cnt=1.
 - abort (ECR=10) while in REQ_LOCKS before grant -> RELEASE with alu_release=0, IDLE next.
 - rs_valid withheld 4 cycles with grant high -> alu_req_valid not asserted until rs_valid; pkt_b_is_imm=1 ignores rt_valid=0.
 - rst_n pulsed during WAIT_ALU -> immediate IDLE, counters 0, pkt_ready=1, late alu_ans_valid ignored.
